fast_detector: RTL and testbench

FAST-9 corner detection stage. It sits directly downstream of the Gaussian convolution stage inside orb_fast. After conv_done, it scans the smoothed image in the conv SRAM in raster order. For each pixel it writes a corner score, or 0, to the FAST SRAM, which the orientation/descriptor stages consume next.

---
 rtl/fast_pkg.sv | 31 +++
 rtl/fast_arc_check.sv | 21 ++
 rtl/fast_detector.sv | 216 +++++++++++++++++++++
 tb/tb_fast_detector.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fast_pkg.sv
// Shared types and constants for the FAST-9 corner detection stage.
package fast_pkg;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, EVAL, WRITE, DONE} state_t;

    localparam int FAST_BORDER = 3;
    localparam int FAST_ARC    = 9;
    localparam int FAST_N      = 16;

    // Bresenham circle of radius 3, clockwise from 12 o'clock.
    localparam logic signed [2:0] CIRCLE_DX [FAST_N] = '{
        3'sd0,  3'sd1,  3'sd2,  3'sd3,  3'sd3,  3'sd3,  3'sd2,  3'sd1,
        3'sd0, -3'sd1, -3'sd2, -3'sd3, -3'sd3, -3'sd3, -3'sd2, -3'sd1
    };
    localparam logic signed [2:0] CIRCLE_DY [FAST_N] = '{
        -3'sd3, -3'sd3, -3'sd2, -3'sd1,  3'sd0,  3'sd1,  3'sd2,  3'sd3,
         3'sd3,  3'sd3,  3'sd2,  3'sd1,  3'sd0, -3'sd1, -3'sd2, -3'sd3
    };

    // Read index 0 is the centre pixel; indices 1..16 walk the circle.
    function automatic logic signed [2:0] read_dx(input logic [4:0] idx);
        if (idx == 5'd0 || idx > 5'(FAST_N)) return 3'sd0;
        return CIRCLE_DX[4'(idx - 5'd1)];
    endfunction

    function automatic logic signed [2:0] read_dy(input logic [4:0] idx);
        if (idx == 5'd0 || idx > 5'(FAST_N)) return 3'sd0;
        return CIRCLE_DY[4'(idx - 5'd1)];
    endfunction

endpackage

// File: rtl/fast_arc_check.sv
// Detects a run of at least FAST_ARC set bits in a circular 16-bit mask.
module fast_arc_check
    import fast_pkg::*;
(
    input  logic [FAST_N-1:0] mask,
    output logic              is_arc
);

    logic [2*FAST_N-1:0] ring;

    assign ring = {mask, mask};

    always_comb begin
        // NOTE: give every always_comb output a value before any branch, or a latch is inferred.
        is_arc = 1'b0;
        for (int s = 0; s < FAST_N; s++) begin
            if (&ring[s +: FAST_ARC]) is_arc = 1'b1;
        end
    end

endmodule

// File: rtl/fast_detector.sv
// FAST-9 corner detector: raster-scans the smoothed image in the conv SRAM and
// writes one score per pixel (0 = not a corner) into the FAST SRAM.
module fast_detector
    import fast_pkg::*;
#(
    parameter int X_MAX       = 400,
    parameter int Y_MAX       = 400,
    parameter int PIXEL_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(X_MAX):0]     max_x,
    input  logic [$clog2(Y_MAX):0]     max_y,
    input  logic [PIXEL_DEPTH-1:0]     threshold,
    output logic [$clog2(X_MAX):0]     x_addr_conv_fast,
    output logic [$clog2(Y_MAX):0]     y_addr_conv_fast,
    output logic                       ren_conv_fast,
    input  logic [PIXEL_DEPTH-1:0]     rdat_conv_fast,
    output logic [$clog2(X_MAX):0]     x_addr_fast,
    output logic [$clog2(Y_MAX):0]     y_addr_fast,
    output logic                       wen_fast,
    output logic [PIXEL_DEPTH-1:0]     wdat_fast,
    output logic                       busy,
    output logic                       done
);

    localparam int XW = $clog2(X_MAX) + 1;
    localparam int YW = $clog2(Y_MAX) + 1;
    localparam int PD = PIXEL_DEPTH;
    localparam int SW = PD + 2;
    localparam int AW = PD + 5;

    localparam logic [XW:0]   BORDER_X  = (XW+1)'(FAST_BORDER);
    localparam logic [YW:0]   BORDER_Y  = (YW+1)'(FAST_BORDER);
    localparam logic [4:0]    LAST_IDX  = 5'(FAST_N);
    localparam logic [PD-1:0] SCORE_MAX = '1;

    state_t          state;
    logic [XW-1:0]   x_q, mx_q;
    logic [YW-1:0]   y_q, my_q;
    logic [PD-1:0]   thr_q;
    logic [4:0]      idx_q, rd_idx_q;
    logic            rd_pend_q;
    logic [PD-1:0]   samples [FAST_N+1];

    logic [XW-1:0]   np_x, lim_x, rd_base_x, rd_x;
    logic [YW-1:0]   np_y, lim_y, rd_base_y, rd_y;
    logic            np_border, last_pixel, advance;
    logic [4:0]      rd_idx_nxt;
    logic signed [2:0] rd_dx, rd_dy;

    // Next pixel in raster order, its border status and the next read address.
    always_comb begin
        lim_x = (state == IDLE) ? max_x : mx_q;
        lim_y = (state == IDLE) ? max_y : my_q;
        if (state == IDLE) begin
            np_x = '0;
            np_y = '0;
        end else if (x_q == mx_q) begin
            np_x = '0;
            np_y = y_q + YW'(1);
        end else begin
            np_x = x_q + XW'(1);
            np_y = y_q;
        end
        np_border = ({1'b0, np_x} < BORDER_X) || ({1'b0, np_x} + BORDER_X > {1'b0, lim_x}) ||
                    ({1'b0, np_y} < BORDER_Y) || ({1'b0, np_y} + BORDER_Y > {1'b0, lim_y});
        last_pixel = (x_q == mx_q) && (y_q == my_q);
        advance    = ((state == IDLE) && start) || ((state == WRITE) && !last_pixel);
        rd_idx_nxt = (state == READ) ? idx_q + 5'd1 : 5'd0;
        rd_base_x  = (state == READ) ? x_q : np_x;
        rd_base_y  = (state == READ) ? y_q : np_y;
        rd_dx      = read_dx(rd_idx_nxt);
        rd_dy      = read_dy(rd_idx_nxt);
        rd_x       = rd_base_x + {{(XW-3){rd_dx[2]}}, rd_dx};
        rd_y       = rd_base_y + {{(YW-3){rd_dy[2]}}, rd_dy};
    end

    // NOTE: the sample buffer is pure datapath, fully rewritten before each EVAL, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rd_pend_q) samples[rd_idx_q] <= rdat_conv_fast;
    end

    logic signed [SW-1:0] c_s, t_s, hi_s, lo_s, p_s;
    logic [FAST_N-1:0]    bright, dark;
    logic [AW-1:0]        sum_b, sum_d, sum_sel;
    logic                 bright_arc, dark_arc;
    logic [PD-1:0]        score;

    // Classification in PD+2 signed bits so c+t and c-t never wrap.
    always_comb begin
        c_s    = signed'({2'b00, samples[0]});
        t_s    = signed'({2'b00, thr_q});
        hi_s   = c_s + t_s;
        lo_s   = c_s - t_s;
        bright = '0;
        dark   = '0;
        sum_b  = '0;
        sum_d  = '0;
        p_s    = '0;
        for (int i = 0; i < FAST_N; i++) begin
            p_s = signed'({2'b00, samples[i+1]});
            if (p_s > hi_s) begin
                bright[i] = 1'b1;
                sum_b     = sum_b + AW'(p_s - hi_s);
            end
            if (p_s < lo_s) begin
                dark[i] = 1'b1;
                sum_d   = sum_d + AW'(lo_s - p_s);
            end
        end
    end

    fast_arc_check u_arc_bright (.mask(bright), .is_arc(bright_arc));
    fast_arc_check u_arc_dark   (.mask(dark),   .is_arc(dark_arc));

    always_comb begin
        sum_sel = '0;
        if (bright_arc)    sum_sel = sum_b;
        else if (dark_arc) sum_sel = sum_d;
        score = (sum_sel > {{(AW-PD){1'b0}}, SCORE_MAX}) ? SCORE_MAX : sum_sel[PD-1:0];
    end

    // Single FSM; every SRAM-facing output is registered and defaults to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            x_q              <= '0;
            y_q              <= '0;
            mx_q             <= '0;
            my_q             <= '0;
            thr_q            <= '0;
            idx_q            <= '0;
            rd_idx_q         <= '0;
            rd_pend_q        <= 1'b0;
            x_addr_conv_fast <= '0;
            y_addr_conv_fast <= '0;
            ren_conv_fast    <= 1'b0;
            x_addr_fast      <= '0;
            y_addr_fast      <= '0;
            wen_fast         <= 1'b0;
            wdat_fast        <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here; later assignments in this block override the defaults.
            x_addr_conv_fast <= '0;
            y_addr_conv_fast <= '0;
            ren_conv_fast    <= 1'b0;
            x_addr_fast      <= '0;
            y_addr_fast      <= '0;
            wen_fast         <= 1'b0;
            wdat_fast        <= '0;
            done             <= 1'b0;
            rd_pend_q        <= ren_conv_fast;
            rd_idx_q         <= idx_q;

            case (state)
                IDLE: begin
                    if (start) begin
                        mx_q  <= max_x;
                        my_q  <= max_y;
                        thr_q <= threshold;
                        busy  <= 1'b1;
                    end
                end
                READ: begin
                    if (idx_q == LAST_IDX) begin
                        state <= DRAIN;
                    end else begin
                        idx_q            <= rd_idx_nxt;
                        ren_conv_fast    <= 1'b1;
                        x_addr_conv_fast <= rd_x;
                        y_addr_conv_fast <= rd_y;
                    end
                end
                DRAIN: state <= EVAL;
                EVAL: begin
                    state       <= WRITE;
                    wen_fast    <= 1'b1;
                    wdat_fast   <= score;
                    x_addr_fast <= x_q;
                    y_addr_fast <= y_q;
                end
                WRITE: begin
                    if (last_pixel) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (advance) begin
                x_q <= np_x;
                y_q <= np_y;
                if (np_border) begin
                    state       <= WRITE;
                    wen_fast    <= 1'b1;
                    x_addr_fast <= np_x;
                    y_addr_fast <= np_y;
                end else begin
                    state            <= READ;
                    idx_q            <= 5'd0;
                    ren_conv_fast    <= 1'b1;
                    x_addr_conv_fast <= rd_x;
                    y_addr_conv_fast <= rd_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_fast_detector.sv
// Self-checking bench for fast_detector: cycle-exact expectation queue built from
// a plain-arithmetic FAST-9 model, plus directed literal checks.
module tb_fast_detector;

    localparam int XW = $clog2(400) + 1;
    localparam int YW = $clog2(400) + 1;
    localparam int CDX [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam int CDY [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

    typedef struct packed {
        logic          ren;
        logic [XW-1:0] rx;
        logic [YW-1:0] ry;
        logic          wen;
        logic [XW-1:0] wx;
        logic [YW-1:0] wy;
        logic [7:0]    wdat;
        logic          busy;
        logic          done;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [XW-1:0] max_x;
    logic [YW-1:0] max_y;
    logic [7:0]    threshold;
    logic [XW-1:0] x_addr_conv_fast, x_addr_fast;
    logic [YW-1:0] y_addr_conv_fast, y_addr_fast;
    logic          ren_conv_fast, wen_fast, busy, done;
    logic [7:0]    rdat_conv_fast;
    logic [7:0]    wdat_fast;

    fast_detector #(.X_MAX(400), .Y_MAX(400), .PIXEL_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .max_x(max_x), .max_y(max_y), .threshold(threshold),
        .x_addr_conv_fast(x_addr_conv_fast), .y_addr_conv_fast(y_addr_conv_fast),
        .ren_conv_fast(ren_conv_fast), .rdat_conv_fast(rdat_conv_fast),
        .x_addr_fast(x_addr_fast), .y_addr_fast(y_addr_fast),
        .wen_fast(wen_fast), .wdat_fast(wdat_fast),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int   img    [16][16];
    int   wr_img [16][16];
    obs_t exp_q[$];
    obs_t act, e;
    int   n_cmp = 0, n_bad = 0;
    int   busy_cnt, ren_cnt, done_cnt, done_at, wr_cnt;
    bit   chk_en = 0;

    // Synchronous-read SRAM; garbage on the bus whenever no read was issued.
    always @(posedge clk) begin
        if (ren_conv_fast) rdat_conv_fast <= 8'(img[int'(y_addr_conv_fast) & 15][int'(x_addr_conv_fast) & 15]);
        else               rdat_conv_fast <= 8'($urandom_range(0, 255));
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic bit has_arc(input bit [15:0] m);
        for (int s = 0; s < 16; s++) begin
            bit run = 1;
            for (int k = 0; k < 9; k++) if (!m[(s + k) % 16]) run = 0;
            if (run) return 1;
        end
        return 0;
    endfunction

    function automatic int model_score(input int x, input int y, input int t);
        int c, p, sb, sd;
        bit [15:0] bm, dm;
        c = img[y][x]; sb = 0; sd = 0; bm = '0; dm = '0;
        for (int i = 0; i < 16; i++) begin
            p = img[y + CDY[i]][x + CDX[i]];
            if (p > c + t) begin bm[i] = 1; sb += p - c - t; end
            if (p < c - t) begin dm[i] = 1; sd += c - t - p; end
        end
        if (has_arc(bm)) return (sb > 255) ? 255 : sb;
        if (has_arc(dm)) return (sd > 255) ? 255 : sd;
        return 0;
    endfunction

    // Expected outputs for every cycle from the first busy cycle to the return to idle.
    function automatic void build(input int mx, input int my, input int t);
        obs_t o;
        exp_q.delete();
        for (int y = 0; y <= my; y++) begin
            for (int x = 0; x <= mx; x++) begin
                if (x < 3 || x > mx - 3 || y < 3 || y > my - 3) begin
                    o = '0; o.busy = 1; o.wen = 1; o.wx = XW'(x); o.wy = YW'(y);
                    exp_q.push_back(o);
                end else begin
                    for (int k = 0; k < 17; k++) begin
                        o = '0; o.busy = 1; o.ren = 1;
                        o.rx = XW'(x + ((k == 0) ? 0 : CDX[k-1]));
                        o.ry = YW'(y + ((k == 0) ? 0 : CDY[k-1]));
                        exp_q.push_back(o);
                    end
                    o = '0; o.busy = 1;
                    exp_q.push_back(o);
                    exp_q.push_back(o);
                    o.wen = 1; o.wx = XW'(x); o.wy = YW'(y); o.wdat = 8'(model_score(x, y, t));
                    exp_q.push_back(o);
                end
            end
        end
        o = '0; o.done = 1;
        exp_q.push_back(o);
        o = '0;
        exp_q.push_back(o);
    endfunction

    // Per-cycle compare, 1 time unit after the active edge.
    always begin
        @(posedge clk);
        #1;
        act = {ren_conv_fast, x_addr_conv_fast, y_addr_conv_fast, wen_fast,
               x_addr_fast, y_addr_fast, wdat_fast, busy, done};
        if (chk_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", act, e);
            end else begin
                check("idle", act, '0);
            end
            if (busy) busy_cnt++;
            if (ren_conv_fast) ren_cnt++;
            if (done) begin done_cnt++; done_at = busy_cnt; end
            if (wen_fast) begin
                wr_cnt++;
                wr_img[int'(y_addr_fast) & 15][int'(x_addr_fast) & 15] = int'(wdat_fast);
            end
        end
    end

    task automatic start_frame(input int mx, input int my, input int t);
        @(negedge clk);
        max_x = XW'(mx); max_y = YW'(my); threshold = 8'(t); start = 1'b1;
        build(mx, my, t);
        busy_cnt = 0; ren_cnt = 0; done_cnt = 0; done_at = -1; wr_cnt = 0;
        for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) wr_img[y][x] = -1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_frame();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("frame_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic fill(input int v);
        for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) img[y][x] = v;
    endtask

    task automatic set_circle(input int cx, input int cy, input bit [15:0] m, input int v);
        for (int i = 0; i < 16; i++) if (m[i]) img[cy + CDY[i]][cx + CDX[i]] = v;
    endtask

    initial begin
        int mx, my, wmax;
        rst = 1'b1; start = 1'b0; max_x = '0; max_y = '0; threshold = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
        repeat (2) @(negedge clk);

        // Flat frame: every write is 0, 16*20 + 84 cycles.
        fill(100);
        start_frame(9, 9, 20);
        finish_frame();
        wmax = 0;
        for (int y = 0; y < 10; y++) for (int x = 0; x < 10; x++) if (wr_img[y][x] > wmax) wmax = wr_img[y][x];
        check("flat_busy_cycles", 64'(busy_cnt), 64'd404);
        check("flat_writes", 64'(wr_cnt), 64'd100);
        check("flat_max_score", 64'(wmax), 64'd0);
        check("flat_done_pulses", 64'(done_cnt), 64'd1);
        check("flat_done_at", 64'(done_at), 64'd404);

        // Dark corner.
        fill(100);
        set_circle(5, 5, 16'hFFFF, 70);
        check("model_dark", 64'(model_score(5, 5, 20)), 64'd160);
        start_frame(9, 9, 20);
        finish_frame();
        check("dark_score", 64'(wr_img[5][5]), 64'd160);

        // Wrap-around arc, saturating; then an 8-long arc.
        fill(100);
        set_circle(5, 5, 16'hF01F, 150);
        check("model_wrap", 64'(model_score(5, 5, 10)), 64'd255);
        start_frame(9, 9, 10);
        finish_frame();
        check("wrap_score", 64'(wr_img[5][5]), 64'd255);
        fill(100);
        set_circle(5, 5, 16'h00FF, 150);
        check("model_arc8", 64'(model_score(5, 5, 10)), 64'd0);
        start_frame(9, 9, 10);
        finish_frame();
        check("arc8_score", 64'(wr_img[5][5]), 64'd0);

        // Threshold equality, then one above.
        fill(100);
        set_circle(5, 5, 16'hFFFF, 110);
        start_frame(9, 9, 10);
        finish_frame();
        check("equal_score", 64'(wr_img[5][5]), 64'd0);
        set_circle(5, 5, 16'hFFFF, 111);
        check("model_above", 64'(model_score(5, 5, 10)), 64'd16);
        start_frame(9, 9, 10);
        finish_frame();
        check("above_score", 64'(wr_img[5][5]), 64'd16);

        // Tiny frame: all border.
        start_frame(4, 4, 20);
        finish_frame();
        check("tiny_busy_cycles", 64'(busy_cnt), 64'd25);
        check("tiny_reads", 64'(ren_cnt), 64'd0);
        check("tiny_writes", 64'(wr_cnt), 64'd25);
        check("tiny_done_at", 64'(done_at), 64'd25);

        // Abort during READ of pixel (4,3), then a fresh full frame.
        fill(100);
        set_circle(5, 5, 16'hFFFF, 70);
        start_frame(9, 9, 20);
        repeat (55) @(negedge clk);
        check("abort_in_read", 64'(ren_conv_fast), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        start_frame(9, 9, 20);
        finish_frame();
        check("restart_busy_cycles", 64'(busy_cnt), 64'd404);
        check("restart_dark_score", 64'(wr_img[5][5]), 64'd160);

        // Randomised frames; the first one also gets a start pulse while busy.
        for (int f = 0; f < 4; f++) begin
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++)
                    img[y][x] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                            : 100 + int'($urandom_range(0, 10));
            mx = (f == 1) ? 6 : int'($urandom_range(6, 15));
            my = int'($urandom_range(6, 15));
            start_frame(mx, my, int'($urandom_range(0, 40)));
            if (f == 0) begin
                repeat (30) @(negedge clk);
                max_x = XW'(4); max_y = YW'(4); threshold = 8'd0; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            finish_frame();
            check("rand_done_pulses", 64'(done_cnt), 64'd1);
            check("rand_writes", 64'(wr_cnt), 64'((mx + 1) * (my + 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
